sram_arbiter: RTL
=================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2, giving the strobe width in clocks (legal range 1..15).
REQ-002 The block SHALL have port clk  input  1  the single system clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port a_req  input  1  CPU-side access request, held until a_ack.
REQ-005 The block SHALL have port a_rw  input  1  CPU-side direction (1 read, 0 write).
REQ-006 The block SHALL have port a_addr  input  17  CPU-side byte address.
REQ-007 The block SHALL have port a_di  input  8  CPU-side write data.
REQ-008 The block SHALL have port a_do  output  8  CPU-side registered read data.
REQ-009 The block SHALL have port a_ack  output  1  CPU-side one-cycle completion pulse.
REQ-010 The block SHALL have ports b_req, b_rw, b_addr, b_di, b_do and b_ack, identical in direction, width and meaning to the a_ ports, for the DMA/video requester.
REQ-011 The block SHALL have port SRAM_AD  output  17  the SRAM address.
REQ-012 The block SHALL have port SRAM_DQ  inout  8  the SRAM data bus.
REQ-013 The block SHALL have ports SRAM_WE_n, SRAM_OE_n and SRAM_CS1_n  output  1  SRAM strobes, all active-low.
REQ-014 The block SHALL have port SRAM_CS2  output  1  SRAM chip select, active-high.

Function
REQ-015 The FSM SHALL have states IDLE, SETUP, STROBE and HOLD; all SRAM outputs SHALL be registered.
REQ-016 In IDLE with any req high, the arbiter SHALL grant a port, latch its addr, rw and di, and go to SETUP at the next edge.
REQ-017 When both req are high in IDLE, the arbiter SHALL grant the port that was not served last (round-robin); when one req is high, it SHALL grant that port.
REQ-018 SETUP SHALL last 1 cycle: SRAM_AD = latched addr, SRAM_CS1_n = 0, SRAM_CS2 = 1, SRAM_WE_n = 1, SRAM_OE_n = 1.
REQ-019 STROBE SHALL last exactly WAIT_CYCLES cycles, timed by a 4-bit counter: reads drive SRAM_OE_n = 0; writes drive SRAM_WE_n = 0 and SRAM_DQ = latched di.
REQ-020 On the last STROBE cycle of a read, the block SHALL capture SRAM_DQ into the granted port's do register.
REQ-021 HOLD SHALL last 1 cycle: SRAM_WE_n = 1 and SRAM_OE_n = 1, chip selects still active, write data still driven, granted port's ack = 1; the next state SHALL be IDLE.
REQ-022 Latency: with req sampled in IDLE at cycle 0, ack SHALL be high in cycle 2+WAIT_CYCLES, and the back-to-back access period SHALL be 3+WAIT_CYCLES cycles.
REQ-023 In IDLE: chip selects inactive, SRAM_WE_n = 1, SRAM_OE_n = 1, SRAM_AD holds its last value.
REQ-024 SRAM_DQ SHALL be high-Z in every state except STROBE and HOLD of a write.
REQ-025 The ungranted port's ack SHALL stay 0; ack SHALL never be high for both ports in the same cycle.
REQ-026 Deassertion of req mid-access SHALL NOT abort the access; the ack pulse still occurs.
REQ-027 a_do and b_do SHALL change only on a read completion for their own port, and SHALL hold across writes and across the other port's accesses.
REQ-028 A requester holding req high through its ack cycle SHALL be treated as a new request in the following IDLE cycle.

Reset
REQ-029 While rst = 1 at a clock edge, the block SHALL enter IDLE with SRAM_AD = 0, SRAM_WE_n = 1, SRAM_OE_n = 1, SRAM_CS1_n = 1, SRAM_CS2 = 0, SRAM_DQ high-Z, a_ack = b_ack = 0, a_do = b_do = 0, counter 0, and last-served = B.
REQ-030 Reset asserted mid-access SHALL abort the access at that edge with no ack; a write in progress may be left incomplete in the SRAM.
REQ-031 The first grant after reset with both requests pending SHALL go to port A.

Verification
REQ-032 WAIT_CYCLES=2, A writes 0x5A to 0x1_2345 -> SRAM_WE_n low for cycles 2-3, SRAM_DQ = 0x5A in cycles 2-4, a_ack high in cycle 4 only.
REQ-033 A reads 0x1_2345 with the SRAM model returning 0x5A -> SRAM_OE_n low for cycles 2-3, a_do = 0x5A from cycle 4 onward, b_do unchanged.
REQ-034 a_req and b_req held high continuously after reset -> grants alternate A, B, A, B, with an ack every 5 cycles.
REQ-035 rst pulsed during STROBE of a B write -> strobes inactive and DQ high-Z next cycle, no b_ack, and the next simultaneous request is granted to A.
REQ-036 b_req dropped during SETUP of a B read -> the access completes, b_ack pulses once, and no second access starts.
REQ-037 WAIT_CYCLES=1 and WAIT_CYCLES=15 builds -> STROBE widths of 1 and 15 cycles, with ack latency of 3 and 17 cycles respectively.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter for an asynchronous 8-bit SRAM.
// Each access: one SETUP cycle, WAIT_CYCLES strobe cycles, one HOLD cycle with ack.
module sram_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req,
    input  logic        a_rw,
    input  logic [16:0] a_addr,
    input  logic [7:0]  a_di,
    output logic [7:0]  a_do,
    output logic        a_ack,
    input  logic        b_req,
    input  logic        b_rw,
    input  logic [16:0] b_addr,
    input  logic [7:0]  b_di,
    output logic [7:0]  b_do,
    output logic        b_ack,
    output logic [16:0] SRAM_AD,
    inout  logic [7:0]  SRAM_DQ,
    output logic        SRAM_WE_n,
    output logic        SRAM_OE_n,
    output logic        SRAM_CS1_n,
    output logic        SRAM_CS2
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t      state, next_state;
    logic [3:0]  cnt;
    logic        last_b;
    logic        grant_b;
    logic        rw_q;
    logic [7:0]  di_q;
    logic        dq_oe;
    logic        pick_b;
    logic        strobe_done;

    always_comb begin
        next_state  = state;
        pick_b      = 1'b0;
        strobe_done = (cnt == 4'(WAIT_CYCLES - 1));
        case (state)
            IDLE: begin
                // B wins when it is alone, or when both ask and A was served last
                pick_b = b_req && (!a_req || !last_b);
                if (a_req || b_req)
                    next_state = SETUP;
            end
            SETUP:  next_state = STROBE;
            STROBE: if (strobe_done) next_state = HOLD;
            HOLD:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Strobes and acks are registered from next_state so they align with the state they belong to
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_b     <= 1'b1;
            grant_b    <= 1'b0;
            rw_q       <= 1'b0;
            di_q       <= '0;
            dq_oe      <= 1'b0;
            SRAM_AD    <= '0;
            SRAM_WE_n  <= 1'b1;
            SRAM_OE_n  <= 1'b1;
            SRAM_CS1_n <= 1'b1;
            SRAM_CS2   <= 1'b0;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            a_do       <= '0;
            b_do       <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state == SETUP) begin
                grant_b <= pick_b;
                last_b  <= pick_b;
                rw_q    <= pick_b ? b_rw   : a_rw;
                di_q    <= pick_b ? b_di   : a_di;
                SRAM_AD <= pick_b ? b_addr : a_addr;
            end
            cnt        <= (state == STROBE && !strobe_done) ? cnt + 4'd1 : '0;
            SRAM_CS1_n <= (next_state == IDLE);
            SRAM_CS2   <= (next_state != IDLE);
            SRAM_WE_n  <= !(next_state == STROBE && !rw_q);
            SRAM_OE_n  <= !(next_state == STROBE && rw_q);
            dq_oe      <= (next_state == STROBE || next_state == HOLD) && !rw_q;
            a_ack      <= (next_state == HOLD) && !grant_b;
            b_ack      <= (next_state == HOLD) && grant_b;
            if (state == STROBE && strobe_done && rw_q) begin
                if (grant_b)
                    b_do <= SRAM_DQ;
                else
                    a_do <= SRAM_DQ;
            end
        end
    end

    assign SRAM_DQ = dq_oe ? di_q : 'z;

endmodule
